// File: rtl/exec_core_cp0_if.sv
// rtl/exec_core_cp0_if.sv - datapath-to-execution-core signal bundle
interface exec_core_cp0_if;
  logic [4:0]  reg_R_addr_A;
  logic [4:0]  reg_R_addr_B;
  logic [4:0]  reg_W_addr;
  logic [31:0] wdata;
  logic        reg_we;
  logic [31:0] rdata_A;
  logic [31:0] rdata_B;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_operation;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic        zero;
  logic        overflow;
  logic [4:0]  c0_rd_addr;
  logic [4:0]  c0_wr_addr;
  logic [31:0] c0_w_data;
  logic        c0_reg_we;
  logic [31:0] pc_i;
  logic [4:0]  InTcause;
  logic        WriteEPC;
  logic        WriteCause;
  logic        WriteInt;
  logic        Int_en_i;
  logic [31:0] Int_en_o;
  logic [31:0] c0_r_data;
  logic [31:0] epc_o;

  modport master (
    output reg_R_addr_A, reg_R_addr_B, reg_W_addr, wdata, reg_we,
    output A, B, ALU_operation, shamt,
    output c0_rd_addr, c0_wr_addr, c0_w_data, c0_reg_we,
    output pc_i, InTcause, WriteEPC, WriteCause, WriteInt, Int_en_i,
    input  rdata_A, rdata_B, res, zero, overflow, Int_en_o, c0_r_data, epc_o
  );

  modport slave (
    input  reg_R_addr_A, reg_R_addr_B, reg_W_addr, wdata, reg_we,
    input  A, B, ALU_operation, shamt,
    input  c0_rd_addr, c0_wr_addr, c0_w_data, c0_reg_we,
    input  pc_i, InTcause, WriteEPC, WriteCause, WriteInt, Int_en_i,
    output rdata_A, rdata_B, res, zero, overflow, Int_en_o, c0_r_data, epc_o
  );
endinterface

// File: rtl/exec_core_cp0.sv
// rtl/exec_core_cp0.sv - MIPS register file, ALU and CP0 (Status/Cause/EPC)
module exec_core_cp0 (
  input  logic          clk,
  input  logic          rst,
  exec_core_cp0_if.slave bus
);
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  logic [31:0] gpr [32];
  logic [31:0] cp0 [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (bus.reg_we && (bus.reg_W_addr != 5'd0)) begin
      gpr[bus.reg_W_addr] <= bus.wdata;
    end
  end

  // No write bypass: a same-cycle read of the target register sees the old value.
  assign bus.rdata_A = (bus.reg_R_addr_A == 5'd0) ? 32'd0 : gpr[bus.reg_R_addr_A];
  assign bus.rdata_B = (bus.reg_R_addr_B == 5'd0) ? 32'd0 : gpr[bus.reg_R_addr_B];

  // Dedicated strobes are issued after the generic mtc0 write so they win on shared bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) cp0[i] <= '0;
    end else begin
      if (bus.c0_reg_we) cp0[bus.c0_wr_addr] <= bus.c0_w_data;
      if (bus.WriteEPC) cp0[CP0_EPC] <= bus.pc_i;
      if (bus.WriteCause) cp0[CP0_CAUSE][6:2] <= bus.InTcause;
      if (bus.WriteInt) cp0[CP0_STATUS][0] <= bus.Int_en_i;
    end
  end

  assign bus.c0_r_data = cp0[bus.c0_rd_addr];
  assign bus.Int_en_o  = cp0[CP0_STATUS];
  assign bus.epc_o     = cp0[CP0_EPC];

  logic [31:0] alu_res;
  logic        alu_ovf;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALU_operation)
      4'b0000: alu_res = bus.A & bus.B;
      4'b0001: alu_res = bus.A | bus.B;
      4'b0010: begin
        alu_res = bus.A + bus.B;
        alu_ovf = (bus.A[31] == bus.B[31]) && (alu_res[31] != bus.A[31]);
      end
      4'b0011: alu_res = bus.A ^ bus.B;
      4'b0100: alu_res = ~(bus.A | bus.B);
      4'b0101: alu_res = bus.B >> bus.shamt;
      4'b0110: begin
        alu_res = bus.A - bus.B;
        alu_ovf = (bus.A[31] != bus.B[31]) && (alu_res[31] != bus.A[31]);
      end
      4'b0111: alu_res = {31'd0, ($signed(bus.A) < $signed(bus.B))};
      4'b1000: alu_res = bus.B << bus.shamt;
      4'b1001: alu_res = $signed(bus.B) >>> bus.shamt;
      4'b1010: alu_res = {31'd0, (bus.A < bus.B)};
      4'b1011: alu_res = {bus.B[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

  assign bus.res      = alu_res;
  assign bus.overflow = alu_ovf;
  assign bus.zero     = (alu_res == 32'd0);
endmodule

// File: tb/tb_exec_core_cp0.sv
// tb/tb_exec_core_cp0.sv - randomized model-checked bench for exec_core_cp0
module tb_exec_core_cp0;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmp_en = 1'b1;
  int total = 0;
  int bad = 0;

  logic [31:0] m_gpr [32];
  logic [31:0] m_cp0 [32];

  always #5 clk = ~clk;

  exec_core_cp0_if bus ();

  exec_core_cp0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, output logic [31:0] r, output logic ov);
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      4'd3:  r = a ^ b;
      4'd4:  r = ~(a | b);
      4'd5:  r = b >> sh;
      4'd6:  begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = b << sh;
      4'd9:  r = b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = b * 32'd65536;
      default: r = 32'd0;
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = '0;
      m_cp0[i] = '0;
    end
  endfunction

  function automatic void model_commit();
    logic [31:0] st, ca;
    if (bus.reg_we && bus.reg_W_addr != 5'd0) m_gpr[bus.reg_W_addr] = bus.wdata;
    st = (bus.c0_reg_we && bus.c0_wr_addr == 5'd12) ? bus.c0_w_data : m_cp0[12];
    ca = (bus.c0_reg_we && bus.c0_wr_addr == 5'd13) ? bus.c0_w_data : m_cp0[13];
    if (bus.c0_reg_we) m_cp0[bus.c0_wr_addr] = bus.c0_w_data;
    if (bus.WriteEPC) m_cp0[14] = bus.pc_i;
    if (bus.WriteCause) ca = (ca & ~32'h7C) | ({27'd0, bus.InTcause} * 4);
    if (bus.WriteInt) st = (st & ~32'h1) | {31'd0, bus.Int_en_i};
    m_cp0[12] = st;
    m_cp0[13] = ca;
  endfunction

  always @(negedge clk) begin
    logic [31:0] r;
    logic ov;
    if (cmp_en) begin
      m_alu(bus.ALU_operation, bus.A, bus.B, bus.shamt, r, ov);
      check("rdata_A", bus.rdata_A, m_gpr[bus.reg_R_addr_A]);
      check("rdata_B", bus.rdata_B, m_gpr[bus.reg_R_addr_B]);
      check("res", bus.res, r);
      check("zero", {31'd0, bus.zero}, {31'd0, (r == 32'd0)});
      check("overflow", {31'd0, bus.overflow}, {31'd0, ov});
      check("c0_r_data", bus.c0_r_data, m_cp0[bus.c0_rd_addr]);
      check("Int_en_o", bus.Int_en_o, m_cp0[12]);
      check("epc_o", bus.epc_o, m_cp0[14]);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst) model_commit();
    #1;
  endtask

  task automatic idle();
    bus.reg_we = 1'b0;
    bus.c0_reg_we = 1'b0;
    bus.WriteEPC = 1'b0;
    bus.WriteCause = 1'b0;
    bus.WriteInt = 1'b0;
  endtask

  task automatic alu_set(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
    bus.ALU_operation = op;
    bus.A = a;
    bus.B = b;
    bus.shamt = sh;
    #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] pick_c0();
    case ($urandom_range(0, 4))
      0: return 5'd12;
      1: return 5'd13;
      2: return 5'd14;
      3: return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic randomize_inputs();
    bus.reg_R_addr_A = 5'($urandom);
    bus.reg_R_addr_B = 5'($urandom);
    bus.reg_W_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    bus.wdata = $urandom;
    bus.reg_we = ($urandom_range(0, 1) == 1);
    bus.A = pick_val();
    bus.B = ($urandom_range(0, 7) == 0) ? bus.A : pick_val();
    bus.ALU_operation = 4'($urandom);
    bus.shamt = 5'($urandom);
    bus.c0_rd_addr = pick_c0();
    bus.c0_wr_addr = pick_c0();
    bus.c0_w_data = $urandom;
    bus.c0_reg_we = ($urandom_range(0, 3) == 0);
    bus.pc_i = $urandom;
    bus.InTcause = 5'($urandom);
    bus.WriteEPC = ($urandom_range(0, 3) == 0);
    bus.WriteCause = ($urandom_range(0, 3) == 0);
    bus.WriteInt = ($urandom_range(0, 3) == 0);
    bus.Int_en_i = 1'($urandom);
  endtask

  initial begin
    model_clear();
    idle();
    bus.reg_R_addr_A = 5'd3; bus.reg_R_addr_B = 5'd7; bus.reg_W_addr = 5'd0; bus.wdata = '0;
    bus.A = '0; bus.B = '0; bus.ALU_operation = 4'd0; bus.shamt = '0;
    bus.c0_rd_addr = 5'd12; bus.c0_wr_addr = '0; bus.c0_w_data = '0;
    bus.pc_i = '0; bus.InTcause = '0; bus.Int_en_i = 1'b0;
    #2;
    check("reset_rdata_A", bus.rdata_A, 32'd0);
    check("reset_Int_en_o", bus.Int_en_o, 32'd0);
    check("reset_zero", {31'd0, bus.zero}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    bus.reg_we = 1'b1; bus.reg_W_addr = 5'd5; bus.wdata = 32'hDEADBEEF; bus.reg_R_addr_A = 5'd5;
    #1;
    check("gpr_same_cycle_old", bus.rdata_A, 32'd0);
    tick();
    bus.reg_W_addr = 5'd0; bus.wdata = 32'h1; bus.reg_R_addr_B = 5'd0;
    #1;
    check("gpr_r5", bus.rdata_A, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("gpr_r0", bus.rdata_B, 32'd0);

    alu_set(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    check("add_res", bus.res, 32'h80000000);
    check("add_ovf", {31'd0, bus.overflow}, 32'd1);
    alu_set(4'b0110, 32'd5, 32'd5, 5'd0);
    check("sub_res", bus.res, 32'd0);
    check("sub_zero", {31'd0, bus.zero}, 32'd1);
    alu_set(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("slt", bus.res, 32'd1);
    alu_set(4'b1010, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("sltu", bus.res, 32'd0);
    alu_set(4'b1001, 32'd0, 32'h80000000, 5'd4);
    check("sra", bus.res, 32'hF8000000);

    bus.pc_i = 32'h100; bus.InTcause = 5'd8; bus.WriteEPC = 1'b1; bus.WriteCause = 1'b1;
    tick();
    idle();
    bus.c0_rd_addr = 5'd13;
    #1;
    check("exc_epc", bus.epc_o, 32'h100);
    check("exc_cause", bus.c0_r_data, 32'h20);

    bus.WriteInt = 1'b1; bus.Int_en_i = 1'b1;
    tick();
    idle();
    #1;
    check("int_en_set", bus.Int_en_o, 32'h1);
    bus.c0_reg_we = 1'b1; bus.c0_wr_addr = 5'd12; bus.c0_w_data = 32'hFF;
    bus.WriteInt = 1'b1; bus.Int_en_i = 1'b0;
    tick();
    idle();
    #1;
    check("int_en_priority", bus.Int_en_o, 32'hFE);

    bus.c0_reg_we = 1'b1; bus.c0_wr_addr = 5'd9; bus.c0_w_data = 32'h1234;
    tick();
    idle();
    bus.c0_rd_addr = 5'd9;
    #1;
    check("mfc0_reg9", bus.c0_r_data, 32'h1234);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
      if (i == 1500) begin
        randomize_inputs();
        bus.reg_R_addr_A = 5'd5;
        bus.c0_rd_addr = 5'd9;
        bus.reg_we = 1'b1;
        rst = 1'b0;
        model_clear();
        #1;
        check("midrst_rdata_A", bus.rdata_A, 32'd0);
        check("midrst_Int_en_o", bus.Int_en_o, 32'd0);
        check("midrst_epc_o", bus.epc_o, 32'd0);
        check("midrst_c0_r_data", bus.c0_r_data, 32'd0);
        tick();
        rst = 1'b1;
      end
    end

    cmp_en = 1'b0;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
